shared_signal_arbiter: RTL

Arbitrates N requesters for exclusive write ownership of one shared registered signal, so the signal always has exactly one driver or a defined default. Tracks the two dataflow hazards our analysis flags statically. An undriven hazard is a signal left without a writer for too long. A write-only hazard is a value overwritten before any reader consumed it. This block sits between multiple producer blocks and a single consumer on a shared configuration or status net.

---
 rtl/shared_signal_arbiter.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/shared_signal_arbiter.sv
// shared_signal_arbiter
// Gives N requesters exclusive, round-robin write ownership of one registered
// shared signal. It also watches two hazards on that signal: a net left
// ownerless too long ("undriven"), and values overwritten before the consumer
// read them (overwrite_cnt).
module shared_signal_arbiter #(
    parameter int                N_REQ          = 4,
    parameter int                WIDTH          = 8,
    parameter logic [WIDTH-1:0]  DEFAULT_VAL    = '0,
    parameter int                UNDRIVEN_LIMIT = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ-1:0]           last,
    input  logic [N_REQ*WIDTH-1:0]     wdata,
    output logic [N_REQ-1:0]           gnt,
    output logic [$clog2(N_REQ)-1:0]   owner_id,
    output logic [WIDTH-1:0]           bus_data,
    output logic                       bus_valid,
    input  logic                       rd_ack,
    output logic                       undriven,
    output logic [7:0]                 overwrite_cnt
);

    localparam int              ID_W    = $clog2(N_REQ);
    localparam logic [ID_W:0]   N_REQ_W = (ID_W+1)'(N_REQ);
    localparam logic [ID_W-1:0] LAST_ID = ID_W'(N_REQ - 1);
    localparam logic [7:0]      LIMIT   = 8'(UNDRIVEN_LIMIT);

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } state_t;

    state_t            state_reg;
    logic [N_REQ-1:0]  gnt_reg;
    logic [ID_W-1:0]   owner_id_reg;
    logic [ID_W-1:0]   ptr_reg;
    logic [WIDTH-1:0]  bus_data_reg;
    logic              bus_valid_reg;
    logic              undriven_reg;
    logic [7:0]        overwrite_cnt_reg;
    logic [7:0]        idle_cnt_reg;

    // Per-requester write data, unpacked for indexing by owner.
    logic [WIDTH-1:0]  wdata_arr [N_REQ];

    // Round-robin selection results.
    logic              sel_found;
    logic [ID_W-1:0]   sel_idx;
    logic [ID_W:0]     cand_sum;
    logic [N_REQ-1:0]  sel_onehot;
    logic [ID_W-1:0]   ptr_next;

    // Current owner's view of its own request lines.
    logic              owner_req;
    logic              owner_last;
    logic [WIDTH-1:0]  owner_wdata;
    logic [7:0]        idle_cnt_next;

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_req
            assign wdata_arr[gi]  = wdata[gi*WIDTH +: WIDTH];
            assign sel_onehot[gi] = (sel_idx == ID_W'(gi));
        end
    endgenerate

    assign owner_req     = req[owner_id_reg];
    assign owner_last    = last[owner_id_reg];
    assign owner_wdata   = wdata_arr[owner_id_reg];
    assign idle_cnt_next = idle_cnt_reg + 8'd1;
    assign ptr_next      = (sel_idx == LAST_ID) ? '0 : sel_idx + 1'b1;

    // Find the first active request at or above the pointer, wrapping mod N_REQ.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand_sum  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand_sum = {1'b0, ptr_reg} + (ID_W+1)'(k);
            if (cand_sum >= N_REQ_W) begin
                cand_sum = cand_sum - N_REQ_W;
            end
            if (!sel_found && req[cand_sum[ID_W-1:0]]) begin
                sel_found = 1'b1;
                sel_idx   = cand_sum[ID_W-1:0];
            end
        end
    end

    // Ownership FSM with registered grant, shared data, and hazard tracking.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg         <= IDLE;
            gnt_reg           <= '0;
            owner_id_reg      <= '0;
            ptr_reg           <= '0;
            bus_data_reg      <= DEFAULT_VAL;
            bus_valid_reg     <= 1'b0;
            undriven_reg      <= 1'b0;
            overwrite_cnt_reg <= '0;
            idle_cnt_reg      <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    // No write happens while idle, so a read simply consumes.
                    if (rd_ack) begin
                        bus_valid_reg <= 1'b0;
                    end
                    if (sel_found) begin
                        // A grant beats the undriven threshold on the same edge.
                        state_reg    <= OWNED;
                        gnt_reg      <= sel_onehot;
                        owner_id_reg <= sel_idx;
                        ptr_reg      <= ptr_next;
                        idle_cnt_reg <= '0;
                        undriven_reg <= 1'b0;
                    end else if (idle_cnt_reg != LIMIT) begin
                        idle_cnt_reg <= idle_cnt_next;
                        // Default is loaded only on the crossing, not while saturated.
                        if (idle_cnt_next == LIMIT) begin
                            undriven_reg  <= 1'b1;
                            bus_data_reg  <= DEFAULT_VAL;
                            bus_valid_reg <= 1'b0;
                        end
                    end
                end

                OWNED: begin
                    if (owner_req) begin
                        bus_data_reg  <= owner_wdata;
                        bus_valid_reg <= 1'b1;
                        // A same-cycle read consumes the old value before it is replaced.
                        if (bus_valid_reg && !rd_ack && (overwrite_cnt_reg != 8'hFF)) begin
                            overwrite_cnt_reg <= overwrite_cnt_reg + 8'd1;
                        end
                        if (owner_last) begin
                            state_reg <= IDLE;
                            gnt_reg   <= '0;
                        end
                    end else begin
                        // Owner abandoned: no write, ownership ends.
                        if (rd_ack) begin
                            bus_valid_reg <= 1'b0;
                        end
                        state_reg <= IDLE;
                        gnt_reg   <= '0;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                    gnt_reg   <= '0;
                end
            endcase
        end
    end

    assign gnt           = gnt_reg;
    assign owner_id      = owner_id_reg;
    assign bus_data      = bus_data_reg;
    assign bus_valid     = bus_valid_reg;
    assign undriven      = undriven_reg;
    assign overwrite_cnt = overwrite_cnt_reg;

endmodule
